// File: rtl/fifo_reader_serializer.sv
// -----------------------------------------------------------------------------
// fifo_reader_serializer
//
// Drain engine for a first-word-fall-through FIFO. Whenever the FIFO reports
// data and fetching is enabled, one word is popped and shifted out MSB-first on
// a 1-bit valid/ready serial stream, followed by GAP_CYCLES idle cycles.
//
// Parameters
//   BITS        FIFO word width / serial frame length (>= 2)
//   GAP_CYCLES  idle cycles inserted after each word (>= 0)
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active high
//   enable      permits fetching new words
//   fifo_ready  FIFO has data (head word valid on fifo_data)
//   fifo_data   FIFO head word
//   fifo_read   one-cycle pop strobe to the FIFO
//   ser_data    current serial bit (0 when ser_valid=0)
//   ser_valid   ser_data is valid
//   ser_first   ser_data carries the MSB of a word
//   ser_ready   sink accepts the bit this cycle
//   busy        engine is not idle
//   word_count  words fully delivered, wraps silently
// -----------------------------------------------------------------------------
module fifo_reader_serializer #(
   parameter int BITS       = 12,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 fifo_ready,
   input  logic [BITS-1:0]      fifo_data,
   output logic                 fifo_read,
   output logic                 ser_data,
   output logic                 ser_valid,
   output logic                 ser_first,
   input  logic                 ser_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] word_count
);

   localparam int BW = $clog2(BITS);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BW-1:0] BIT_TOP = BW'(BITS - 1);
   localparam logic [GW-1:0] GAP_TOP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_e;

   state_e                 state_q,      state_d;
   logic [BITS-1:0]        shreg_q,      shreg_d;
   logic [BW-1:0]          bit_cnt_q,    bit_cnt_d;
   logic [GW-1:0]          gap_cnt_q,    gap_cnt_d;
   logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;

   logic fetch;

   // A pop is only possible while idle; all other states ignore the FIFO side.
   assign fetch = (state_q == ST_IDLE) & enable & fifo_ready;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         word_count_q <= word_count_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every _d signal is given its hold value first so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      word_count_d = word_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (fetch) begin
               shreg_d   = fifo_data;
               bit_cnt_d = BIT_TOP;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (ser_ready) begin
               shreg_d   = {shreg_q[BITS-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - BW'(1);
               // Last bit accepted: the word counts as delivered.
               if (bit_cnt_q == '0) begin
                  word_count_d = word_count_q + CNT_WIDTH'(1);
                  if (GAP_CYCLES > 0) begin
                     gap_cnt_d = GAP_TOP;
                     state_d   = ST_GAP;
                  end else begin
                     state_d   = ST_IDLE;
                  end
               end
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   // Reset is synchronous, so the registers still hold pre-reset values during
   // the reset cycle; the outputs are masked so the sink and FIFO see a quiet
   // interface for the whole time rst is high.
   always_comb begin
      fifo_read  = fetch & ~rst;
      ser_valid  = (state_q == ST_SHIFT) & ~rst;
      ser_data   = ser_valid & shreg_q[BITS-1];
      ser_first  = ser_valid & (bit_cnt_q == BIT_TOP);
      busy       = (state_q != ST_IDLE) & ~rst;
      word_count = rst ? '0 : word_count_q;
   end

endmodule

// File: tb/tb_fifo_reader_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader_serializer
//
// Directed scenarios plus a randomized phase. A queue models the FIFO contents;
// every popped word expands into its BITS bits MSB-first in an expected-bit
// queue, and each accepted serial bit is compared against the queue head.
// Inputs change just after the falling edge, outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_reader_serializer;

   localparam int BITS       = 12;
   localparam int GAP_CYCLES = 1;
   localparam int CNT_WIDTH  = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic                 fifo_ready;
   logic [BITS-1:0]      fifo_data;
   logic                 fifo_read;
   logic                 ser_data;
   logic                 ser_valid;
   logic                 ser_first;
   logic                 ser_ready;
   logic                 busy;
   logic [CNT_WIDTH-1:0] word_count;

   always #5 clk = ~clk;

   fifo_reader_serializer #(
      .BITS       (BITS),
      .GAP_CYCLES (GAP_CYCLES),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_ready (fifo_ready),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .ser_data   (ser_data),
      .ser_valid  (ser_valid),
      .ser_first  (ser_first),
      .ser_ready  (ser_ready),
      .busy       (busy),
      .word_count (word_count)
   );

   typedef struct {
      bit b;
      bit first;
      bit last;
   } exp_bit_t;

   // Reference model state
   logic [BITS-1:0]      fq[$];
   exp_bit_t             exp_q[$];
   logic [CNT_WIDTH-1:0] exp_wc;

   int n_cmp = 0;
   int n_err = 0;
   int rdy_mode;   // 0: always ready, 1: alternating, 2: random
   int cyc = 0;
   int acc_bits;   // index of the next bit of the current word

   // Samples of the current cycle and of the previous one
   logic s_rd, s_v, s_d, s_f, s_busy;
   logic p_v = 0, p_d = 0, p_f = 0, p_rdy = 0, p_rst = 1;

   // Per-scenario statistics
   int n_rd, n_v, n_f, n_busy, first_v, last_v, rd_at;
   logic [BITS-1:0] got_bits;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      n_rd = 0; n_v = 0; n_f = 0; n_busy = 0;
      first_v = -1; last_v = -1; rd_at = -1;
      got_bits = '0;
   endtask

   // One clock cycle: present inputs, sample, check, update model, advance.
   task automatic step();
      exp_bit_t        e;
      logic [BITS-1:0] w;
      case (rdy_mode)
         1:       ser_ready = cyc[0];
         2:       ser_ready = 1'($urandom_range(0, 1));
         default: ser_ready = 1'b1;
      endcase
      fifo_ready = (fq.size() > 0);
      fifo_data  = (fq.size() > 0) ? fq[0] : '0;
      #1;
      s_rd = fifo_read; s_v = ser_valid; s_d = ser_data; s_f = ser_first; s_busy = busy;

      chk("read_without_ready", {31'd0, s_rd & ~fifo_ready}, 0);
      chk("data_while_invalid", {31'd0, s_d & ~s_v}, 0);
      chk("first_while_invalid", {31'd0, s_f & ~s_v}, 0);

      if (rst) begin
         chk("reset_outputs", {27'd0, s_rd, s_v, s_d, s_f, s_busy}, 0);
         chk("reset_word_count", {16'd0, word_count}, 0);
         exp_q.delete();
         exp_wc   = '0;
         acc_bits = 0;
      end else begin
         chk("word_count", {16'd0, word_count}, {16'd0, exp_wc});
         if (p_v && !p_rdy && !p_rst)
            chk("hold_under_backpressure", {29'd0, s_v, s_d, s_f}, {29'd0, 1'b1, p_d, p_f});
         if (s_v && ser_ready) begin
            chk("bit_was_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("ser_data", {31'd0, s_d}, {31'd0, e.b});
               chk("ser_first", {31'd0, s_f}, {31'd0, e.first});
               if (e.last) begin
                  exp_wc   = exp_wc + 1'b1;
                  acc_bits = 0;
               end else begin
                  acc_bits++;
               end
            end
            got_bits = {got_bits[BITS-2:0], s_d};
         end
         if (s_rd && fq.size() > 0) begin
            w = fq.pop_front();
            for (int i = BITS - 1; i >= 0; i--)
               exp_q.push_back('{b: w[i], first: (i == BITS - 1), last: (i == 0)});
         end
      end

      if (s_rd) begin n_rd++; if (rd_at < 0) rd_at = cyc; end
      if (s_v) begin n_v++; if (first_v < 0) first_v = cyc; last_v = cyc; end
      if (s_f) n_f++;
      if (s_busy) n_busy++;

      p_v = s_v; p_d = s_d; p_f = s_f; p_rdy = ser_ready; p_rst = rst;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; rdy_mode = 0;
      fq.delete();
      run(2);
      rst = 1'b0;
      clear_stats();
   endtask

   logic [BITS-1:0] w_rand;
   int              reached;

   initial begin
      rst = 1'b1; enable = 1'b0; ser_ready = 1'b1; rdy_mode = 0;
      fifo_ready = 1'b0; fifo_data = '0; exp_wc = '0; acc_bits = 0;
      clear_stats();
      @(negedge clk);

      // 1: single word 0xA5C with a sink that is always ready
      do_reset();
      fq.push_back(12'hA5C);
      enable = 1'b1;
      run(20);
      chk("t1_read_pulses", n_rd, 1);
      chk("t1_fetch_to_valid", first_v - rd_at, 1);
      chk("t1_valid_cycles", n_v, 12);
      chk("t1_contiguous", last_v - first_v, 11);
      chk("t1_first_count", n_f, 1);
      chk("t1_bits", {20'd0, got_bits}, 32'hA5C);
      chk("t1_word_count", {16'd0, word_count}, 1);
      chk("t1_busy_after_gap", {31'd0, s_busy}, 0);

      // 2: same word, sink ready on alternate cycles
      do_reset();
      fq.push_back(12'hA5C);
      enable = 1'b1;
      rdy_mode = 1;
      run(40);
      chk("t2_span_23_24", {31'd0, (last_v - first_v + 1 >= 23) && (last_v - first_v + 1 <= 24)}, 1);
      chk("t2_no_holes", n_v, last_v - first_v + 1);
      chk("t2_bits", {20'd0, got_bits}, 32'hA5C);
      chk("t2_word_count", {16'd0, word_count}, 1);

      // 3: back-to-back words 0xFFF and 0x001
      do_reset();
      fq.push_back(12'hFFF);
      fq.push_back(12'h001);
      enable = 1'b1;
      run(40);
      chk("t3_read_pulses", n_rd, 2);
      chk("t3_valid_cycles", n_v, 24);
      chk("t3_idle_between", (last_v - first_v + 1) - n_v, 2);
      chk("t3_second_word", {20'd0, got_bits}, 32'h001);
      chk("t3_word_count", {16'd0, word_count}, 2);

      // 4: enable dropped while bit index 5 is on the line
      do_reset();
      fq.push_back(BITS'($urandom));
      fq.push_back(BITS'($urandom));
      enable = 1'b1;
      reached = 0;
      for (int i = 0; i < 40 && reached == 0; i++) begin
         step();
         if (s_busy && acc_bits == 5) begin
            enable  = 1'b0;
            reached = 1;
         end
      end
      chk("t4_reached_bit5", reached, 1);
      clear_stats();
      run(30);
      chk("t4_no_read_disabled", n_rd, 0);
      chk("t4_rest_delivered", n_v, BITS - 5);
      chk("t4_word_count", {16'd0, word_count}, 1);
      chk("t4_model_drained", exp_q.size(), 0);
      enable = 1'b1;
      clear_stats();
      step();
      chk("t4_immediate_refetch", {31'd0, s_rd}, 1);
      run(20);
      chk("t4_second_word_done", {16'd0, word_count}, 2);

      // 5: reset pulse while bit 6 of 0xA5C is on the line
      do_reset();
      w_rand = BITS'($urandom);
      fq.push_back(12'hA5C);
      fq.push_back(w_rand);
      enable = 1'b1;
      reached = 0;
      for (int i = 0; i < 40 && reached == 0; i++) begin
         step();
         if (s_busy && acc_bits == 6) reached = 1;
      end
      chk("t5_reached_bit6", reached, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("t5_valid_after_rst", {31'd0, s_v}, 0);
      chk("t5_busy_after_rst", {31'd0, s_busy}, 0);
      chk("t5_wc_after_rst", {16'd0, word_count}, 0);
      clear_stats();
      run(30);
      chk("t5_next_word", {20'd0, got_bits}, {20'd0, w_rand});
      chk("t5_valid_cycles", n_v, BITS);
      chk("t5_word_count", {16'd0, word_count}, 1);

      // 6: enabled but empty FIFO
      do_reset();
      enable = 1'b1;
      run(20);
      chk("t6_no_read", n_rd, 0);
      chk("t6_no_valid", n_v, 0);
      chk("t6_not_busy", n_busy, 0);
      chk("t6_word_count", {16'd0, word_count}, 0);

      // 7: random traffic, backpressure, enable toggling and rare resets
      do_reset();
      rdy_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 2) == 0 && fq.size() < 3) fq.push_back(BITS'($urandom));
         enable = ($urandom_range(0, 5) != 0);
         rst    = ($urandom_range(0, 150) == 0);
         step();
      end
      rst = 1'b0;
      enable = 1'b1;
      run(150);
      chk("t7_fifo_empty", fq.size(), 0);
      chk("t7_bits_drained", exp_q.size(), 0);
      chk("t7_idle_at_end", {31'd0, s_busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
